// File: rtl/comm_master_n.sv
// UART command transmitter: sends CMD_BYTES bytes MSB byte first as back-to-back 8N1 frames.
// Define COMM_CHKSUM_EN to append a frame carrying ~(modulo-256 sum of the command bytes).
module comm_master_n #(
    parameter int CMD_BYTES = 2,
    parameter int BAUD_DIV  = 2604
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snd_cmd,
    input  logic [8*CMD_BYTES-1:0] cmd,
    output logic                   TX,
    output logic                   cmd_cmplt,
    output logic                   busy
);

`ifdef COMM_CHKSUM_EN
    localparam int NB = CMD_BYTES + 1;
`else
    localparam int NB = CMD_BYTES;
`endif
    localparam int BUF_W = 8 * NB;
    localparam int CW    = $clog2(CMD_BYTES + 1);
    localparam int BW    = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(NB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CW-1:0]      byte_q, byte_d;
    logic [2:0]         bit_q, bit_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               cmplt_q, cmplt_d;
    logic               tick;
    logic [7:0]         top_byte;

`ifdef COMM_CHKSUM_EN
    function automatic logic [BUF_W-1:0] load_buf(input logic [8*CMD_BYTES-1:0] c);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < CMD_BYTES; i++) s = s + c[8*i +: 8];
        return {c, ~s};
    endfunction
`else
    function automatic logic [BUF_W-1:0] load_buf(input logic [8*CMD_BYTES-1:0] c);
        return c;
    endfunction
`endif

    assign tick     = (baud_q == BAUD_MAX);
    assign top_byte = buf_d[BUF_W-1 -: 8];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        busy_d  = busy_q;
        cmplt_d = cmplt_q;
        if (state_q != IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    buf_d   = load_buf(cmd);
                    cmplt_d = 1'b0;
                    busy_d  = 1'b1;
                    byte_d  = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_q == BYTE_LAST) begin
                        byte_d  = '0;
                        cmplt_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // Next byte moves into the top lane; start bit follows with no gap.
                        byte_d  = byte_q + 1'b1;
                        buf_d   = buf_q << 8;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = top_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            cmplt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            cmplt_q <= cmplt_d;
        end
    end

    assign TX        = tx_q;
    assign busy      = busy_q;
    assign cmd_cmplt = cmplt_q;

endmodule

// File: tb/tb_comm_master_n.sv
// Bench for comm_master_n: three instances (2, 1 and 8 command bytes) at BAUD_DIV=4.
module tb_comm_master_n;
    localparam int B = 4;
`ifdef COMM_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snd;
    logic [63:0] cmdv;
    int          sel;
    logic        tx2, busy2, cc2, tx1, busy1, cc1, tx8, busy8, cc8;
    logic        tx_s, busy_s, cc_s;
    int          n_pass = 0;
    int          n_total = 0;
    logic        done [3];
    int          nbytes [3] = '{2, 1, 8};

    always #5 clk = ~clk;

    comm_master_n #(.CMD_BYTES(2), .BAUD_DIV(B)) u2 (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd && sel == 0), .cmd(cmdv[15:0]),
        .TX(tx2), .cmd_cmplt(cc2), .busy(busy2));
    comm_master_n #(.CMD_BYTES(1), .BAUD_DIV(B)) u1 (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd && sel == 1), .cmd(cmdv[7:0]),
        .TX(tx1), .cmd_cmplt(cc1), .busy(busy1));
    comm_master_n #(.CMD_BYTES(8), .BAUD_DIV(B)) u8 (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd && sel == 2), .cmd(cmdv),
        .TX(tx8), .cmd_cmplt(cc8), .busy(busy8));

    assign tx_s   = (sel == 0) ? tx2   : (sel == 1) ? tx1   : tx8;
    assign busy_s = (sel == 0) ? busy2 : (sel == 1) ? busy1 : busy8;
    assign cc_s   = (sel == 0) ? cc2   : (sel == 1) ? cc1   : cc8;

    task automatic chk(input string name, input int j, input logic [2:0] act, input logic [2:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst=%0d j=%0d: tx/busy/cmplt got %b want %b", name, sel, j, act, exp);
    endtask

    // Reference frame stream: byte list (plus optional checksum), each framed as 0, d0..d7, 1.
    function automatic logic exp_tx(input logic [63:0] c, input int nb, input int j);
        int idx, f, pos;
        logic [7:0] by, s;
        idx = j / B;
        f   = idx / 10;
        pos = idx % 10;
        if (f >= nb + CHK) return 1'b1;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        if (f < nb) begin
            by = 8'((c >> (8 * (nb - 1 - f))) & 64'hFF);
        end else begin
            s = 8'h00;
            for (int i = 0; i < nb; i++) s = s + 8'((c >> (8 * i)) & 64'hFF);
            by = ~s;
        end
        return by[pos-1];
    endfunction

    task automatic idle_check(input int n);
        for (int g = 0; g < n; g++) begin
            chk("idle", g, {tx_s, busy_s, cc_s}, {1'b1, 1'b0, done[sel]});
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int s, input logic [63:0] c, input int ign1, input int ign2,
                           input int lat, input int gap);
        idle_check(gap);
        sel  = s;
        cmdv = c;
        snd  = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        for (int j = 0; j <= lat; j++) begin
            chk("frame", j, {tx_s, busy_s, cc_s},
                {exp_tx(c, nbytes[s], j), (j < lat) ? 1'b1 : 1'b0, (j >= lat) ? 1'b1 : 1'b0});
            if (j + 1 == ign1 || j + 1 == ign2) begin
                snd  = 1'b1;
                cmdv = 64'h1234;
            end else begin
                snd = 1'b0;
            end
            if (j < lat) @(negedge clk);
        end
        snd = 1'b0;
        done[s] = 1'b1;
    endtask

    typedef struct {
        int          inst;
        logic [63:0] cmd;
        int          ign1;
        int          ign2;
        int          lat;
        int          gap;
    } vec_t;

    vec_t vecs [5];

    initial begin
        rst_n = 1'b0;
        snd   = 1'b0;
        cmdv  = '0;
        sel   = 0;
        for (int i = 0; i < 3; i++) done[i] = 1'b0;

        vecs[0] = '{0, 64'hA5C3,             -1, -1,                 80 + 40 * CHK, 5};
        vecs[1] = '{0, 64'hA5C3,             30, 80 + 40 * CHK,      80 + 40 * CHK, 3};
        vecs[2] = '{0, 64'h1234,             -1, -1,                 80 + 40 * CHK, 0};
        vecs[3] = '{1, 64'h00,               -1, -1,                 40 + 40 * CHK, 4};
        vecs[4] = '{2, 64'h0102030405060708, -1, -1,                320 + 40 * CHK, 2};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1 chk("reset", i, {tx_s, busy_s, cc_s}, 3'b100);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(100);

        // Reset during the data bits of the first byte.
        cmdv = 64'hA5C3;
        snd  = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst", 14, {tx_s, busy_s, cc_s}, {exp_tx(64'hA5C3, 2, 14), 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 0, {tx_s, busy_s, cc_s}, 3'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_check(30);

        for (int v = 0; v < 5; v++)
            run_vec(vecs[v].inst, vecs[v].cmd, vecs[v].ign1, vecs[v].ign2, vecs[v].lat, vecs[v].gap);
        idle_check(5);

        for (int r = 0; r < 8; r++) begin
            int s;
            s = int'($urandom_range(0, 2));
            run_vec(s, {$urandom, $urandom}, -1, -1, (nbytes[s] + CHK) * 10 * B,
                    int'($urandom_range(0, 5)));
        end
        idle_check(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
